// File: rtl/mem_bus_loader_if.sv
// Native picorv32-style memory bus between the byte-driven loader (master)
// and a memory/IO responder (slave).
interface mem_bus_loader_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_loader.sv
// Byte-stream command decoder that issues single 32-bit word transfers on
// the native memory bus and returns an ack byte or read data on a
// flow-controlled byte output.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for an opcode byte ('W' 0x57 or 'R' 0x52)
// ADDR   | collecting 4 little-endian address bytes
// DATA   | collecting 4 little-endian write-data bytes (write only)
// BUS    | mem_valid high, waiting for mem_ready or timeout
// RESP   | presenting response bytes until each is accepted
module mem_bus_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [7:0]              in_byte,
    input  logic                    in_byte_en,
    mem_bus_loader_if.master        bus,
    output logic [7:0]              out_byte,
    output logic                    out_byte_en,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    rx_overrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    // Terminal count for the wait counter; reaching it with ready low aborts.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic        op_write;
    logic [1:0]  byte_cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] wait_cnt;
    logic [31:0] resp_sh;
    logic [2:0]  resp_left;

    // Bus and byte-output signals decoded from the registered state.
    assign bus.mem_valid = (state == S_BUS);
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr & 32'hFFFF_FFFC;
    assign bus.mem_wdata = wdata;
    assign bus.mem_wstrb = (state == S_BUS && op_write) ? 4'b1111 : 4'b0000;

    assign out_byte_en = (state == S_RESP);
    assign out_byte    = resp_sh[7:0];
    assign busy        = (state == S_BUS) || (state == S_RESP);

    // Command parsing, bus transfer, timeout and response sequencing.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= S_IDLE;
            op_write   <= 1'b0;
            byte_cnt   <= 2'd0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            wait_cnt   <= 16'd0;
            resp_sh    <= 32'd0;
            resp_left  <= 3'd0;
            rx_overrun <= 1'b0;
        end else begin
            if (in_byte_en && busy) begin
                rx_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (in_byte_en) begin
                        if (in_byte == OP_WRITE) begin
                            op_write <= 1'b1;
                            byte_cnt <= 2'd0;
                            state    <= S_ADDR;
                        end else if (in_byte == OP_READ) begin
                            op_write <= 1'b0;
                            byte_cnt <= 2'd0;
                            state    <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    if (in_byte_en) begin
                        addr[{byte_cnt, 3'b000} +: 8] <= in_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wait_cnt <= 16'd0;
                            state    <= op_write ? S_DATA : S_BUS;
                        end
                    end
                end

                S_DATA: begin
                    if (in_byte_en) begin
                        wdata[{byte_cnt, 3'b000} +: 8] <= in_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wait_cnt <= 16'd0;
                            state    <= S_BUS;
                        end
                    end
                end

                S_BUS: begin
                    // Completion takes priority over an expiry on the same edge.
                    if (bus.mem_ready) begin
                        if (op_write) begin
                            resp_sh   <= {24'd0, RSP_OK};
                            resp_left <= 3'd1;
                        end else begin
                            resp_sh   <= bus.mem_rdata;
                            resp_left <= 3'd4;
                        end
                        state <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        resp_sh   <= {24'd0, RSP_ERR};
                        resp_left <= 3'd1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                S_RESP: begin
                    if (out_ready) begin
                        resp_sh   <= {8'd0, resp_sh[31:8]};
                        resp_left <= resp_left - 3'd1;
                        if (resp_left == 3'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_loader.sv
// Directed bench for mem_bus_loader: write, read, timeout, backpressure,
// overrun, garbage bytes and mid-transfer reset.
module tb_mem_bus_loader;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] in_byte;
    logic       in_byte_en;
    logic [7:0] out_byte;
    logic       out_byte_en;
    logic       out_ready;
    logic       busy;
    logic       rx_overrun;

    int n_pass  = 0;
    int n_total = 0;

    mem_bus_loader_if bus ();

    mem_bus_loader #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_byte     (in_byte),
        .in_byte_en  (in_byte_en),
        .bus         (bus.master),
        .out_byte    (out_byte),
        .out_byte_en (out_byte_en),
        .out_ready   (out_ready),
        .busy        (busy),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=stalled expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte    = b;
        in_byte_en = 1'b1;
        tick();
        in_byte_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_bytes [4];
        int idx;
        int cnt;
        int k;

        resetn         = 1'b1;
        in_byte        = 8'h00;
        in_byte_en     = 1'b0;
        out_ready      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        tick();
        tick();

        check("rst_valid",   {31'd0, bus.mem_valid}, 32'd0);
        check("rst_wstrb",   {28'd0, bus.mem_wstrb}, 32'd0);
        check("rst_addr",    bus.mem_addr, 32'd0);
        check("rst_wdata",   bus.mem_wdata, 32'd0);
        check("rst_out_en",  {31'd0, out_byte_en}, 32'd0);
        check("rst_out",     {24'd0, out_byte}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        resetn = 1'b0;
        tick();

        // Garbage bytes followed by a write with a ready after 2 cycles.
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_valid",   {31'd0, bus.mem_valid}, 32'd0);
        check("garbage_overrun", {31'd0, rx_overrun}, 32'd0);
        send_byte(8'h57);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
        check("wr_valid_pre", {31'd0, bus.mem_valid}, 32'd0);
        send_byte(8'hDE);
        check("wr_valid",  {31'd0, bus.mem_valid}, 32'd1);
        check("wr_busy",   {31'd0, busy}, 32'd1);
        check("wr_addr",   bus.mem_addr, 32'h0000_0010);
        check("wr_wdata",  bus.mem_wdata, 32'hDEAD_BEEF);
        check("wr_wstrb",  {28'd0, bus.mem_wstrb}, 32'hF);
        check("wr_instr",  {31'd0, bus.mem_instr}, 32'd0);
        tick();
        check("wr_valid2", {31'd0, bus.mem_valid}, 32'd1);
        check("wr_addr2",  bus.mem_addr, 32'h0000_0010);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("wr_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        check("wr_resp_en",    {31'd0, out_byte_en}, 32'd1);
        check("wr_resp",       {24'd0, out_byte}, 32'h4B);
        tick();
        check("wr_resp_hold_en", {31'd0, out_byte_en}, 32'd1);
        check("wr_resp_hold",    {24'd0, out_byte}, 32'h4B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("wr_done_en",   {31'd0, out_byte_en}, 32'd0);
        check("wr_done_busy", {31'd0, busy}, 32'd0);

        // Read with an overrun byte strobed during BUS.
        send_byte(8'h52);
        send_byte(8'h12); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("rd_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("rd_addr",  bus.mem_addr, 32'h0000_0010);
        check("rd_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
        send_byte(8'h57);
        check("ovr_set",       {31'd0, rx_overrun}, 32'd1);
        check("ovr_valid",     {31'd0, bus.mem_valid}, 32'd1);
        check("ovr_addr",      bus.mem_addr, 32'h0000_0010);
        bus.mem_rdata = 32'h1122_3344;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        check("rd_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        check("rd_b0_en", {31'd0, out_byte_en}, 32'd1);
        check("rd_b0",    {24'd0, out_byte}, 32'h44);
        out_ready = 1'b1;
        tick();
        check("rd_b1", {24'd0, out_byte}, 32'h33);
        tick();
        check("rd_b2", {24'd0, out_byte}, 32'h22);
        tick();
        check("rd_b3",    {24'd0, out_byte}, 32'h11);
        check("rd_b3_en", {31'd0, out_byte_en}, 32'd1);
        tick();
        out_ready = 1'b0;
        check("rd_done_en",   {31'd0, out_byte_en}, 32'd0);
        check("rd_done_busy", {31'd0, busy}, 32'd0);

        // Read response under 1-of-3 backpressure.
        send_byte(8'h52);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        bus.mem_rdata = 32'hA1B2_C3D4;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        exp_bytes[0] = 8'hD4;
        exp_bytes[1] = 8'hC3;
        exp_bytes[2] = 8'hB2;
        exp_bytes[3] = 8'hA1;
        idx = 0;
        k = 0;
        while (idx < 4 && k < 30) begin
            check("bp_en",   {31'd0, out_byte_en}, 32'd1);
            check("bp_byte", {24'd0, out_byte}, {24'd0, exp_bytes[idx]});
            out_ready = (k % 3 == 2);
            tick();
            if (out_ready) idx++;
            k++;
        end
        out_ready = 1'b0;
        check("bp_count",    idx, 32'd4);
        check("bp_done_en",  {31'd0, out_byte_en}, 32'd0);
        check("ovr_sticky",  {31'd0, rx_overrun}, 32'd1);

        // Timeout with ready stuck low.
        send_byte(8'h52);
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        cnt = 0;
        while (bus.mem_valid && cnt < 50) begin
            cnt++;
            tick();
        end
        check("to_valid_cycles", cnt, 32'd8);
        check("to_resp_en", {31'd0, out_byte_en}, 32'd1);
        check("to_resp",    {24'd0, out_byte}, 32'h45);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("to_done_en",   {31'd0, out_byte_en}, 32'd0);
        check("to_done_busy", {31'd0, busy}, 32'd0);

        // Ready arriving on the last allowed cycle wins over the timeout.
        send_byte(8'h52);
        send_byte(8'h34); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 7; i++) tick();
        check("edge_valid8", {31'd0, bus.mem_valid}, 32'd1);
        bus.mem_rdata = 32'h5566_7788;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        check("edge_b0_en", {31'd0, out_byte_en}, 32'd1);
        check("edge_b0",    {24'd0, out_byte}, 32'h88);
        out_ready = 1'b1;
        tick();
        check("edge_b1", {24'd0, out_byte}, 32'h77);
        tick();
        check("edge_b2", {24'd0, out_byte}, 32'h66);
        tick();
        check("edge_b3", {24'd0, out_byte}, 32'h55);
        tick();
        out_ready = 1'b0;
        check("edge_done_en", {31'd0, out_byte_en}, 32'd0);

        // Back-to-back write in the first non-busy cycle, then reset mid-BUS.
        send_byte(8'h57);
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("b2b_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("b2b_addr",  bus.mem_addr, 32'h0000_0040);
        check("b2b_wdata", bus.mem_wdata, 32'h0403_0201);
        tick();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        check("mrst_valid",   {31'd0, bus.mem_valid}, 32'd0);
        check("mrst_busy",    {31'd0, busy}, 32'd0);
        check("mrst_overrun", {31'd0, rx_overrun}, 32'd0);
        bus.mem_ready = 1'b1;
        out_ready     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_resp",  {31'd0, out_byte_en}, 32'd0);
            check("mrst_no_valid", {31'd0, bus.mem_valid}, 32'd0);
        end
        bus.mem_ready = 1'b0;
        out_ready     = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_loader.md
# mem_bus_loader

Byte-stream-driven initiator on the picorv32 native memory interface, the bus-master counterpart of the memory/IO responder on the same bus. It receives command bytes (write word / read word) from a byte source such as a UART receiver and issues single 32-bit transfers with `mem_valid`/`mem_ready` handshaking. It returns an ack byte or read data on a flow-controlled byte output. Typical uses are firmware download and memory peek/poke while the core is held in reset.

## Interface
- `TIMEOUT`, 1024: maximum cycles `mem_valid` is held without `mem_ready` before abort; legal range 2..65535.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  synchronous, active-high reset. High = reset, sampled on `clk`; the name follows the board button convention.
- `in_byte`  in  8  command byte stream.
- `in_byte_en`  in  1  one-cycle strobe; `in_byte` valid this cycle.
- `mem_valid`  out  1  transfer request.
- `mem_instr`  out  1  constant 0.
- `mem_ready`  in  1  responder completion.
- `mem_addr`  out  32  word address; bits [1:0] always 0.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'b1111 for write, 4'b0000 for read.
- `mem_rdata`  in  32  read data, valid when `mem_valid && mem_ready`.
- `out_byte`  out  8  response byte.
- `out_byte_en`  out  1  response valid; held until accepted.
- `out_ready`  in  1  sink accepts `out_byte` when `out_byte_en && out_ready`.
- `busy`  out  1  high in BUS and RESP states; input bytes dropped.
- `rx_overrun`  out  1  sticky; set when a byte arrives while `busy`.

## Operation
- Reset: every output register is 0, including `mem_*`, `out_*`, `busy` and `rx_overrun`. State is IDLE and all counters are 0.
- Command format (all multi-byte fields little-endian):
  - 0x57 'W' + 4 address bytes + 4 data bytes.
  - 0x52 'R' + 4 address bytes.
- States: IDLE → ADDR → (DATA if write) → BUS → RESP → IDLE.
- IDLE:
  - 0x57 or 0x52 latches the opcode and moves to ADDR with byte counter 0.
  - Any other byte is ignored; `rx_overrun` is unaffected.
- ADDR: each strobe fills `addr[8*i+:8]`. After byte 3, a write goes to DATA and a read goes to BUS. `addr[1:0]` is forced to 0 when driven.
- DATA: each strobe fills `wdata[8*i+:8]`. After byte 3, go to BUS.
- No inter-byte timeout exists; a partial command waits indefinitely.
- BUS:
  - `mem_valid` = 1. `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for the whole request.
  - A 16-bit wait counter starts at 0 and increments each cycle with `mem_valid && !mem_ready`.
- Completion: on the edge sampling `mem_valid && mem_ready`, capture `mem_rdata` (reads only) and go to RESP.
  - Response for a write is 0x4B 'K'.
  - Response for a read is 4 data bytes, LSB first.
- Timeout: when the counter reaches `TIMEOUT-1` with `mem_ready` still low, abort and go to RESP. The response is a single 0x45 'E' (no data on a read).
  - If `mem_ready` is high on the expiry cycle, completion wins.
- RESP:
  - `out_byte_en` = 1 and `out_byte` is the current response byte.
  - The byte advances only on `out_byte_en && out_ready`.
  - After the last byte is accepted, return to IDLE.
- Any `in_byte_en` while `busy` is dropped and sets `rx_overrun`. Only reset clears `rx_overrun`.
- Reset mid-command or mid-transfer discards all partial state. `mem_valid` and `out_byte_en` are low from the cycle after reset is sampled.

## Timing
- Last payload byte strobed at edge N → `mem_valid` high from N+1.
- Handshake sampled at edge M → `mem_valid` low from M+1; the core never holds valid for a second cycle after ready.
- `out_byte_en` first high at M+1. With `out_ready` held high, a read emits 4 bytes on consecutive cycles M+1..M+4 and IDLE is reached at M+5.
- With `mem_ready` tied low, `mem_valid` is high exactly `TIMEOUT` cycles, then 'E' appears the next cycle.
- `busy` rises with `mem_valid` and falls the cycle after the final response handshake. A byte strobed in that first non-busy cycle is accepted.
- Back-to-back commands need no idle gap beyond the `busy` window.

## Test plan
- Write: send 57 10 00 00 00 EF BE AD DE with a responder giving ready after 2 cycles → one request with addr 0x00000010, wdata 0xDEADBEEF, wstrb 4'hF, then a single 'K' (0x4B).
- Read: send 52 12 00 00 00 with responder rdata 0x11223344 → `mem_addr` 0x00000010, wstrb 0, output bytes 44 33 22 11.
- Timeout: TIMEOUT=8 with `mem_ready` stuck low and a read command → `mem_valid` high exactly 8 cycles, output only 0x45. Repeat with ready arriving on the 8th cycle → data bytes, no 'E'.
- Backpressure and overrun:
  - Toggle `out_ready` 1-of-3 cycles during a read response → each byte held stable until accepted, order preserved.
  - Strobe a byte during BUS → dropped and `rx_overrun` becomes 1 and stays 1.
- Garbage and reset: send 0x00, 0xFF, then a valid write → garbage ignored and the write proceeds normally. Assert `resetn` one cycle mid-BUS → `mem_valid` low the next cycle and no response is emitted.
